// File: rtl/route_boot_pkg.sv
// Shared types and widths for the route-table boot sequencer.
package route_boot_pkg;

    localparam int unsigned ENTRY_W     = 256;
    localparam int unsigned ADDR_W      = 6;
    localparam int unsigned CNT_W       = 7;
    localparam int unsigned SW_ID_W     = 4;
    localparam int unsigned MAX_ENTRIES = 64;
    localparam int unsigned TMR_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RDR_RST = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [ENTRY_W-1:0] data;
    } tbl_entry_t;

    // Entry counter increment that holds at MAX_ENTRIES.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(MAX_ENTRIES)) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/route_boot_timer.sv
// Loadable down-counter shared by the reader reset hold and the WAIT timeout.
module route_boot_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire_c
);

    logic [W-1:0] cnt_q;

    // Load wins over clear so a restart from IDLE/DONE arms immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/route_boot_sequencer.sv
// Boot controller: loads each switch's route table through the shared reader,
// with per-attempt timeout and bounded retry, and reports per-switch status.
module route_boot_sequencer
    import route_boot_pkg::*;
#(
    parameter int unsigned NUM_SWITCHES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned RST_CYCLES     = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            boot_start,
    output logic                            rdr_rst_n,
    output logic                            rdr_start,
    output logic [SW_ID_W-1:0]              rdr_switch_id,
    input  logic                            rdr_done,
    input  logic                            rdr_error,
    input  logic                            rdr_entry_valid,
    input  logic [ADDR_W-1:0]               rdr_entry_addr,
    input  logic [ENTRY_W-1:0]              rdr_entry_data,
    output logic [NUM_SWITCHES-1:0]         tbl_we,
    output logic [ADDR_W-1:0]               tbl_addr,
    output logic [ENTRY_W-1:0]              tbl_data,
    output logic                            busy,
    output logic                            boot_done,
    output logic                            boot_error,
    output logic [NUM_SWITCHES-1:0]         fail_mask,
    output logic [CNT_W*NUM_SWITCHES-1:0]   entry_counts
);

    localparam int unsigned IDX_W   = (NUM_SWITCHES > 1) ? $clog2(NUM_SWITCHES) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t             state_q, state_d;
    logic [SW_ID_W-1:0] cur_id_q;
    logic [IDX_W-1:0]   cur_idx;
    logic [RETRY_W-1:0] retry_q;
    logic [CNT_W-1:0]   cnt_q [NUM_SWITCHES];
    tbl_entry_t         ent_q;

    logic               boot_go_c;
    logic               can_retry_c;
    logic               attempt_fail_c;
    logic               tmr_clear_c;
    logic               tmr_load_c;
    logic               tmr_dec_c;
    logic               tmr_expire_c;
    logic [TMR_W-1:0]   tmr_load_val_c;

    assign cur_idx     = IDX_W'(cur_id_q);
    assign boot_go_c   = boot_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign can_retry_c = (retry_q < RETRY_W'(MAX_RETRY));

    route_boot_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clear_c),
        .load     (tmr_load_c),
        .load_val (tmr_load_val_c),
        .dec      (tmr_dec_c),
        .expire_c (tmr_expire_c)
    );

    // Next-state and timer control.
    always_comb begin
        state_d        = state_q;
        attempt_fail_c = 1'b0;
        tmr_clear_c    = 1'b0;
        tmr_load_c     = 1'b0;
        tmr_load_val_c = '0;
        tmr_dec_c      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                tmr_clear_c = 1'b1;
                if (boot_start) begin
                    state_d = ST_RDR_RST;
                end
            end
            ST_RDR_RST: begin
                if (tmr_expire_c) begin
                    state_d = ST_START;
                end else begin
                    tmr_dec_c = 1'b1;
                end
            end
            ST_START: begin
                tmr_load_c     = 1'b1;
                tmr_load_val_c = TMR_W'(TIMEOUT_CYCLES - 1);
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                // Error outranks done when both arrive together.
                if (rdr_error) begin
                    attempt_fail_c = 1'b1;
                end else if (rdr_done) begin
                    state_d = ST_NEXT;
                end else if (tmr_expire_c) begin
                    attempt_fail_c = 1'b1;
                end else begin
                    tmr_dec_c = 1'b1;
                end
                if (attempt_fail_c) begin
                    state_d = can_retry_c ? ST_RDR_RST : ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_d = (cur_id_q == SW_ID_W'(NUM_SWITCHES - 1)) ? ST_DONE : ST_RDR_RST;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_d == ST_RDR_RST) && (state_q != ST_RDR_RST)) begin
            tmr_load_c     = 1'b1;
            tmr_load_val_c = TMR_W'(RST_CYCLES - 1);
        end
    end

    // State, reader handshake outputs and boot status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_id_q   <= '0;
            retry_q    <= '0;
            rdr_rst_n  <= 1'b0;
            rdr_start  <= 1'b0;
            busy       <= 1'b0;
            boot_done  <= 1'b0;
            boot_error <= 1'b0;
            fail_mask  <= '0;
        end else begin
            state_q   <= state_d;
            rdr_rst_n <= (state_d == ST_START) || (state_d == ST_WAIT);
            rdr_start <= (state_d == ST_START);
            busy      <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            if (boot_go_c) begin
                fail_mask  <= '0;
                boot_done  <= 1'b0;
                boot_error <= 1'b0;
                cur_id_q   <= '0;
                retry_q    <= '0;
            end
            if (attempt_fail_c) begin
                if (can_retry_c) begin
                    retry_q <= retry_q + RETRY_W'(1);
                end else begin
                    fail_mask[cur_idx] <= 1'b1;
                end
            end
            if (state_q == ST_NEXT) begin
                retry_q <= '0;
                if (state_d == ST_DONE) begin
                    boot_done  <= 1'b1;
                    boot_error <= |fail_mask;
                end else begin
                    cur_id_q <= cur_id_q + SW_ID_W'(1);
                end
            end
        end
    end

    assign rdr_switch_id = cur_id_q;

    // Entries are forwarded one cycle later to the current switch's table only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_we <= '0;
            ent_q  <= '0;
        end else begin
            tbl_we <= '0;
            if ((state_q == ST_WAIT) && rdr_entry_valid) begin
                tbl_we     <= NUM_SWITCHES'(1) << cur_idx;
                ent_q.addr <= rdr_entry_addr;
                ent_q.data <= rdr_entry_data;
            end
        end
    end

    assign tbl_addr = ent_q.addr;
    assign tbl_data = ent_q.data;

    // Per-switch entry counters; each attempt starts its switch from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '{default: '0};
        end else if (boot_go_c) begin
            cnt_q <= '{default: '0};
        end else if (state_q == ST_RDR_RST) begin
            cnt_q[cur_idx] <= '0;
        end else if ((state_q == ST_WAIT) && rdr_entry_valid) begin
            cnt_q[cur_idx] <= sat_inc(cnt_q[cur_idx]);
        end
    end

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_cnt
        assign entry_counts[CNT_W*g +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_route_boot_sequencer.sv
// Bench for route_boot_sequencer: scripted reader model plus an attempt-level reference.
module tb_route_boot_sequencer;

    localparam int unsigned NSW   = 2;
    localparam int unsigned TMO   = 100;
    localparam int unsigned MAXR  = 2;
    localparam int unsigned RSTC  = 2;
    localparam int unsigned TMO_B = 16;

    logic clk;
    logic rst_n;
    logic boot_start, rdr_done, rdr_error, rdr_entry_valid;
    logic [5:0] rdr_entry_addr;
    logic [255:0] rdr_entry_data;
    logic rdr_rst_n, rdr_start, busy, boot_done, boot_error;
    logic [3:0] rdr_switch_id;
    logic [NSW-1:0] tbl_we, fail_mask;
    logic [5:0] tbl_addr;
    logic [255:0] tbl_data;
    logic [7*NSW-1:0] entry_counts;

    logic b_boot_start, b_rdr_rst_n, b_rdr_start, b_busy, b_boot_done, b_boot_error;
    logic [3:0] b_rdr_switch_id;
    logic [NSW-1:0] b_tbl_we, b_fail_mask;
    logic [5:0] b_tbl_addr;
    logic [255:0] b_tbl_data;
    logic [7*NSW-1:0] b_entry_counts;

    route_boot_sequencer #(.NUM_SWITCHES(NSW), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .rst_n(rst_n), .boot_start(boot_start),
        .rdr_rst_n(rdr_rst_n), .rdr_start(rdr_start), .rdr_switch_id(rdr_switch_id),
        .rdr_done(rdr_done), .rdr_error(rdr_error), .rdr_entry_valid(rdr_entry_valid),
        .rdr_entry_addr(rdr_entry_addr), .rdr_entry_data(rdr_entry_data),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .busy(busy), .boot_done(boot_done), .boot_error(boot_error),
        .fail_mask(fail_mask), .entry_counts(entry_counts));

    // Silent reader with a short timeout.
    route_boot_sequencer #(.NUM_SWITCHES(NSW), .TIMEOUT_CYCLES(TMO_B), .MAX_RETRY(MAXR), .RST_CYCLES(RSTC)) dut_tmo (
        .clk(clk), .rst_n(rst_n), .boot_start(b_boot_start),
        .rdr_rst_n(b_rdr_rst_n), .rdr_start(b_rdr_start), .rdr_switch_id(b_rdr_switch_id),
        .rdr_done(1'b0), .rdr_error(1'b0), .rdr_entry_valid(1'b0),
        .rdr_entry_addr(6'd0), .rdr_entry_data(256'd0),
        .tbl_we(b_tbl_we), .tbl_addr(b_tbl_addr), .tbl_data(b_tbl_data),
        .busy(b_busy), .boot_done(b_boot_done), .boot_error(b_boot_error),
        .fail_mask(b_fail_mask), .entry_counts(b_entry_counts));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Attempt kinds: 0 ok, 1 error, 2 silent, 3 done+error together
    int plan_kind [NSW][MAXR+1];
    int plan_n    [NSW][MAXR+1];
    logic [2:0] acts[$];
    bit in_att, noise_en, start_req;
    int run_len, exp_run, att_entries, cur_kind;
    int exp_sw, exp_att;
    int exp_cnt [NSW];
    int starts  [NSW];
    logic [NSW-1:0] pend_we;
    logic [5:0] pend_addr;
    logic [255:0] pend_data;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_sw(input int s, input int k0, input int n0, input int k1, input int n1,
                          input int k2, input int n2);
        plan_kind[s][0] = k0; plan_n[s][0] = n0;
        plan_kind[s][1] = k1; plan_n[s][1] = n1;
        plan_kind[s][2] = k2; plan_n[s][2] = n2;
    endtask

    // Script the reader's per-WAIT-cycle behaviour for one attempt.
    task automatic build(input int kind, input int n);
        acts.delete();
        att_entries = n;
        cur_kind = kind;
        for (int i = 0; i < n; i++) begin
            if (n <= 20 && $urandom_range(0, 3) == 0) acts.push_back(3'b000);
            acts.push_back(3'b001);
        end
        case (kind)
            0: if (n > 0 && $urandom_range(0, 3) == 0) acts[acts.size()-1] = 3'b011;
               else acts.push_back(3'b010);
            1: acts.push_back(3'b100);
            3: acts.push_back(3'b110);
            default: ;
        endcase
        exp_run = 1 + ((kind == 2) ? TMO : acts.size());
    endtask

    task automatic model_reset();
        in_att = 0;
        acts.delete();
        pend_we = '0;
        start_req = 0;
    endtask

    // One clock: observe at negedge, update the reference, then drive the reader.
    task automatic step();
        logic [2:0] a;
        logic [255:0] d;
        @(negedge clk);
        if (pend_we !== '0 || tbl_we !== '0) chk("tbl_we", tbl_we, pend_we);
        if (pend_we !== '0) begin
            chk("tbl_addr", tbl_addr, pend_addr);
            chk("tbl_data", tbl_data, pend_data);
        end
        if (in_att && rdr_rst_n === 1'b0) begin
            in_att = 0;
            chk("wait_len", run_len, exp_run);
            if (exp_sw < NSW) begin
                exp_cnt[exp_sw] = (att_entries > 64) ? 64 : att_entries;
                if (cur_kind == 0) begin
                    exp_sw++; exp_att = 0;
                end else begin
                    exp_att++;
                    if (exp_att > MAXR) begin exp_sw++; exp_att = 0; end
                end
            end
        end
        if (rdr_start === 1'b1) begin
            if (rdr_switch_id < NSW) starts[rdr_switch_id]++;
            if (exp_sw < NSW) begin
                chk("switch_id", rdr_switch_id, exp_sw);
                build(plan_kind[exp_sw][exp_att], plan_n[exp_sw][exp_att]);
            end else begin
                chk("extra_start", exp_sw, NSW - 1);
                acts.delete();
                exp_run = 0;
            end
            in_att = 1;
            run_len = 0;
        end
        if (in_att && rdr_rst_n === 1'b1) run_len++;
        pend_we = '0;
        rdr_entry_valid = 0; rdr_done = 0; rdr_error = 0;
        boot_start = start_req;
        start_req = 0;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        rdr_entry_data = d;
        rdr_entry_addr = 6'($urandom);
        if (in_att && rdr_rst_n === 1'b1 && rdr_start === 1'b0) begin
            a = (acts.size() > 0) ? acts.pop_front() : 3'b000;
            rdr_entry_valid = a[0]; rdr_done = a[1]; rdr_error = a[2];
            if (a[0] && exp_sw < NSW) begin
                pend_we[exp_sw] = 1'b1;
                pend_addr = rdr_entry_addr;
                pend_data = rdr_entry_data;
            end
        end else if (noise_en) begin
            rdr_entry_valid = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_boot(input string name, input int pulse_at);
        logic [NSW-1:0] mask_exp;
        int att_exp;
        int c;
        exp_sw = 0; exp_att = 0;
        for (int s = 0; s < NSW; s++) begin exp_cnt[s] = 0; starts[s] = 0; end
        start_req = 1;
        step();
        c = 0;
        do begin
            if (c == pulse_at) begin
                chk({name, "_busy"}, busy, 1'b1);
                start_req = 1;
            end
            step();
            c++;
        end while (boot_done !== 1'b1 && c < 5000);
        chk({name, "_boot_done"}, boot_done, 1'b1);
        chk({name, "_busy_end"}, busy, 1'b0);
        chk({name, "_rdr_rst_n_end"}, rdr_rst_n, 1'b0);
        chk({name, "_switches_done"}, exp_sw, NSW);
        mask_exp = '0;
        for (int s = 0; s < NSW; s++) begin
            att_exp = MAXR + 1;
            for (int a = MAXR; a >= 0; a--) if (plan_kind[s][a] == 0) att_exp = a + 1;
            mask_exp[s] = (att_exp == MAXR + 1) && (plan_kind[s][MAXR] != 0);
            chk({name, "_starts"}, starts[s], att_exp);
            chk({name, "_entry_count"}, entry_counts[7*s +: 7], exp_cnt[s]);
        end
        chk({name, "_fail_mask"}, fail_mask, mask_exp);
        chk({name, "_boot_error"}, boot_error, |mask_exp);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_rdr_rst_n"}, rdr_rst_n, 1'b0);
        chk({name, "_rdr_start"}, rdr_start, 1'b0);
        chk({name, "_switch_id"}, rdr_switch_id, 4'd0);
        chk({name, "_tbl_we"}, tbl_we, '0);
        chk({name, "_tbl_addr"}, tbl_addr, 6'd0);
        chk({name, "_tbl_data"}, tbl_data, 256'd0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_boot_done"}, boot_done, 1'b0);
        chk({name, "_boot_error"}, boot_error, 1'b0);
        chk({name, "_fail_mask"}, fail_mask, '0);
        chk({name, "_entry_counts"}, entry_counts, '0);
    endtask

    initial begin
        int c, wait_cyc, brun, nruns;
        int b_starts [NSW];
        rst_n = 0; boot_start = 0; b_boot_start = 0;
        rdr_done = 0; rdr_error = 0; rdr_entry_valid = 0;
        rdr_entry_addr = '0; rdr_entry_data = '0;
        noise_en = 0; exp_sw = 0; exp_att = 0;
        model_reset();
        repeat (3) step();
        chk_zero_outputs("reset");
        chk("reset_b_rdr_rst_n", b_rdr_rst_n, 1'b0);
        rst_n = 1;
        step();

        // Two clean switches, with an ignored boot_start while busy.
        set_sw(0, 0, 3, 0, 0, 0, 0);
        set_sw(1, 0, 5, 0, 0, 0, 0);
        run_boot("t1", 6);
        // Switch 1 errors on every attempt.
        set_sw(0, 0, $urandom_range(0, 6), 0, 0, 0, 0);
        set_sw(1, 1, 2, 3, 1, 1, 0);
        run_boot("t2", -1);
        // Error then success: count reflects only the successful attempt.
        set_sw(0, 1, 3, 0, 4, 0, 0);
        set_sw(1, 0, 2, 0, 0, 0, 0);
        run_boot("t4", -1);
        // Saturation, a silent attempt, and stray valids outside WAIT.
        noise_en = 1;
        set_sw(0, 0, 70, 0, 0, 0, 0);
        set_sw(1, 2, 3, 0, 6, 0, 0);
        run_boot("t6", -1);
        // Randomized plans.
        for (int r = 0; r < 6; r++) begin
            noise_en = 1'($urandom_range(0, 1));
            for (int s = 0; s < NSW; s++) begin
                for (int a = 0; a <= MAXR; a++) begin
                    c = $urandom_range(0, 19);
                    plan_kind[s][a] = (c < 10) ? 0 : (c < 14) ? 1 : (c < 17) ? 3 : 2;
                    plan_n[s][a] = $urandom_range(0, 10);
                end
            end
            run_boot("rand", -1);
        end

        // Synchronous reset in the middle of WAIT.
        noise_en = 0;
        set_sw(0, 0, 8, 0, 0, 0, 0);
        set_sw(1, 0, 8, 0, 0, 0, 0);
        exp_sw = 0; exp_att = 0;
        start_req = 1;
        step();
        wait_cyc = 0; c = 0;
        while (wait_cyc < 3 && c < 200) begin
            step();
            c++;
            if (rdr_rst_n === 1'b1 && rdr_start === 1'b0) wait_cyc++;
        end
        chk("midrst_reached_wait", wait_cyc, 3);
        rst_n = 0;
        model_reset();
        step();
        chk_zero_outputs("midrst");
        rst_n = 1;
        repeat (5) step();
        chk("midrst_idle_rdr_rst_n", rdr_rst_n, 1'b0);
        chk("midrst_idle_busy", busy, 1'b0);
        chk("midrst_idle_start", rdr_start, 1'b0);
        run_boot("post_rst", -1);

        // Never-responding reader: 16-cycle WAIT, three attempts per switch.
        for (int s = 0; s < NSW; s++) b_starts[s] = 0;
        brun = 0; nruns = 0;
        b_boot_start = 1;
        step();
        b_boot_start = 0;
        for (c = 0; c < 2000; c++) begin
            step();
            if (b_rdr_start === 1'b1 && b_rdr_switch_id < NSW) b_starts[b_rdr_switch_id]++;
            if (b_rdr_rst_n === 1'b1) brun++;
            else if (brun > 0) begin
                chk("tmo_attempt_len", brun, TMO_B + 1);
                brun = 0;
                nruns++;
            end
            if (b_boot_done === 1'b1) break;
        end
        chk("tmo_boot_done", b_boot_done, 1'b1);
        chk("tmo_attempts", nruns, 3 * NSW);
        for (int s = 0; s < NSW; s++) chk("tmo_starts", b_starts[s], MAXR + 1);
        chk("tmo_fail_mask", b_fail_mask, {NSW{1'b1}});
        chk("tmo_boot_error", b_boot_error, 1'b1);
        chk("tmo_entry_counts", b_entry_counts, '0);
        chk("tmo_tbl_we", b_tbl_we, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
